// File: rtl/switch_input_ctrl.sv
// Memory-mapped switch/button input controller: synchronises raw inputs, debounces
// buttons, keeps sticky read-to-clear rising-edge flags and serves a registered read bus.
module switch_input_ctrl #(
  parameter int NUM_BYTES       = 3,
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int ADDR_W          = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   switchCtrl,
  input  logic                   ioRead,
  input  logic [ADDR_W-1:0]      switchAddr,
  input  logic [8*NUM_BYTES-1:0] switches,
  input  logic [NUM_BTNS-1:0]    buttons,
  output logic [15:0]            input_data,
  output logic                   btn_pending
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_FLAGS = ADDR_W'(NUM_BYTES);
  localparam logic [ADDR_W-1:0] ADDR_LEVEL = ADDR_W'(NUM_BYTES + 1);

  logic [8*NUM_BYTES-1:0] sw_s1, sw_s2;
  logic [NUM_BTNS-1:0]    btn_s1, btn_s2;
  logic [NUM_BTNS-1:0]    stable, stable_nxt;
  logic [NUM_BTNS-1:0]    flags, flags_nxt;
  logic [NUM_BTNS-1:0]    rise;
  logic [CNT_W-1:0]       cnt     [NUM_BTNS];
  logic [CNT_W-1:0]       cnt_nxt [NUM_BTNS];
  logic                   rd;
  logic                   flags_clr;
  logic [15:0]            rdata;

  assign rd        = switchCtrl & ioRead;
  assign flags_clr = rd && (switchAddr == ADDR_FLAGS);

  // Debounce: a level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    stable_nxt = stable;
    for (int b = 0; b < NUM_BTNS; b++) begin
      cnt_nxt[b] = '0;
      if (btn_s2[b] != stable[b]) begin
        if (cnt[b] == CNT_LAST) stable_nxt[b] = btn_s2[b];
        else                    cnt_nxt[b]    = cnt[b] + CNT_W'(1);
      end
    end
  end

  // A new rising edge overrides a simultaneous read-to-clear.
  assign rise      = stable_nxt & ~stable;
  assign flags_nxt = (flags_clr ? '0 : flags) | rise;

  always_comb begin
    rdata = 16'h0000;
    for (int k = 0; k < NUM_BYTES; k++) begin
      if (switchAddr == ADDR_W'(k)) rdata = {8'h00, sw_s2[8*k +: 8]};
    end
    if (switchAddr == ADDR_FLAGS) rdata[NUM_BTNS-1:0] = flags;
    if (switchAddr == ADDR_LEVEL) rdata[NUM_BTNS-1:0] = stable;
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '0;
      btn_s2     <= '0;
      stable     <= '0;
      flags      <= '0;
      input_data <= 16'h0000;
      // NOTE: the counters are plain flops, not RAM, so each element is reset explicitly.
      for (int b = 0; b < NUM_BTNS; b++) cnt[b] <= '0;
    end else begin
      sw_s1  <= switches;
      sw_s2  <= sw_s1;
      btn_s1 <= buttons;
      btn_s2 <= btn_s1;
      stable <= stable_nxt;
      flags  <= flags_nxt;
      for (int b = 0; b < NUM_BTNS; b++) cnt[b] <= cnt_nxt[b];
      if (rd) input_data <= rdata;
    end
  end

  assign btn_pending = |flags;

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed self-checking bench for switch_input_ctrl (3 switch bytes, 2 buttons, 4-cycle debounce).
module tb_switch_input_ctrl;

  localparam int NUM_BYTES = 3;
  localparam int NUM_BTNS  = 2;
  localparam int DEB       = 4;
  localparam int ADDR_W    = 4;
  localparam logic [3:0] A_FLAGS = 4'd3;
  localparam logic [3:0] A_LEVEL = 4'd4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   switchCtrl;
  logic                   ioRead;
  logic [ADDR_W-1:0]      switchAddr;
  logic [8*NUM_BYTES-1:0] switches;
  logic [NUM_BTNS-1:0]    buttons;
  logic [15:0]            input_data;
  logic                   btn_pending;

  int n_cmp = 0;
  int n_bad = 0;

  switch_input_ctrl #(
    .NUM_BYTES(NUM_BYTES), .NUM_BTNS(NUM_BTNS),
    .DEBOUNCE_CYCLES(DEB), .ADDR_W(ADDR_W)
  ) dut (
    .clock(clock), .reset(reset), .switchCtrl(switchCtrl), .ioRead(ioRead),
    .switchAddr(switchAddr), .switches(switches), .buttons(buttons),
    .input_data(input_data), .btn_pending(btn_pending)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-edge read strobe; returns input_data sampled just after the edge.
  task automatic do_read(input logic [3:0] a, output logic [15:0] d);
    switchCtrl = 1'b1;
    ioRead     = 1'b1;
    switchAddr = a;
    tick();
    d          = input_data;
    switchCtrl = 1'b0;
    ioRead     = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    reset = 1'b1; switches = 24'hA5C3F0; buttons = '0;
    switchCtrl = 1'b1; ioRead = 1'b1; switchAddr = 4'd0;
    tick(); tick(); tick();
    n_cmp++; if (input_data !== 16'h0000) begin n_bad++; $display("FAIL reset_data got=%h exp=0000", input_data); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got=%b exp=0", btn_pending); end
    reset = 1'b0; switchCtrl = 1'b0; ioRead = 1'b0;
    tick(); tick();
    do_read(4'd0, d);
    n_cmp++; if (d !== 16'h00F0) begin n_bad++; $display("FAIL read_byte0 got=%h exp=00F0", d); end
    do_read(4'd1, d);
    n_cmp++; if (d !== 16'h00C3) begin n_bad++; $display("FAIL read_byte1 got=%h exp=00C3", d); end
    do_read(4'd2, d);
    n_cmp++; if (d !== 16'h00A5) begin n_bad++; $display("FAIL read_byte2 got=%h exp=00A5", d); end
    tick();
    n_cmp++; if (input_data !== 16'h00A5) begin n_bad++; $display("FAIL hold_no_rd got=%h exp=00A5", input_data); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_flags got=%h exp=0000", d); end
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL reset_level got=%h exp=0000", d); end
    do_read(4'd7, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL read_unmapped got=%h exp=0000", d); end
  endtask

  task automatic test_sync_latency();
    logic [15:0] d;
    switches = 24'hA5C300;
    tick(); tick(); tick();
    switches = 24'hA5C33C;
    tick();
    do_read(4'd0, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL sync_n1 got=%h exp=0000", d); end
    do_read(4'd0, d);
    n_cmp++; if (d !== 16'h003C) begin n_bad++; $display("FAIL sync_n2 got=%h exp=003C", d); end
  endtask

  task automatic test_debounce_glitch();
    logic [15:0] d;
    buttons = 2'b01;
    tick(); tick(); tick();
    buttons = 2'b00;
    for (int i = 0; i < 6; i++) tick();
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL glitch_level got=%h exp=0000", d); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL glitch_pending got=%b exp=0", btn_pending); end
  endtask

  task automatic test_debounce_hold();
    logic [15:0] d;
    buttons = 2'b01;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL hold_early_pending edge=N+%0d got=%b exp=0", i, btn_pending); end
    end
    tick();
    n_cmp++; if (btn_pending !== 1'b1) begin n_bad++; $display("FAIL hold_pending_n5 got=%b exp=1", btn_pending); end
    for (int i = 0; i < 4; i++) tick();
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL hold_level got=%h exp=0001", d); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL hold_flags got=%h exp=0001", d); end
    buttons = 2'b00;
    for (int i = 0; i < 8; i++) tick();
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL release_level got=%h exp=0000", d); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL release_pending got=%b exp=0", btn_pending); end
  endtask

  task automatic test_read_to_clear();
    logic [15:0] d;
    buttons = 2'b10;
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if (btn_pending !== 1'b1) begin n_bad++; $display("FAIL rtc_pending_set got=%b exp=1", btn_pending); end
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL rtc_level got=%h exp=0002", d); end
    n_cmp++; if (btn_pending !== 1'b1) begin n_bad++; $display("FAIL rtc_level_keeps_flag got=%b exp=1", btn_pending); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL rtc_first got=%h exp=0002", d); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL rtc_pending_clr got=%b exp=0", btn_pending); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL rtc_second got=%h exp=0000", d); end
    buttons = 2'b00;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_set_wins();
    logic [15:0] d;
    buttons = 2'b01;
    for (int i = 0; i < 5; i++) tick();
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL setwins_read got=%h exp=0000", d); end
    n_cmp++; if (btn_pending !== 1'b1) begin n_bad++; $display("FAIL setwins_pending got=%b exp=1", btn_pending); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0001) begin n_bad++; $display("FAIL setwins_next got=%h exp=0001", d); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL setwins_cleared got=%b exp=0", btn_pending); end
    buttons = 2'b00;
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    do_read(4'd0, d);
    n_cmp++; if (d !== 16'h003C) begin n_bad++; $display("FAIL b2b_0 got=%h exp=003C", d); end
    do_read(4'd1, d);
    n_cmp++; if (d !== 16'h00C3) begin n_bad++; $display("FAIL b2b_1 got=%h exp=00C3", d); end
    do_read(4'd2, d);
    n_cmp++; if (d !== 16'h00A5) begin n_bad++; $display("FAIL b2b_2 got=%h exp=00A5", d); end
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0000) begin n_bad++; $display("FAIL b2b_level got=%h exp=0000", d); end
  endtask

  task automatic test_reset_mid_debounce();
    logic [15:0] d;
    do_read(4'd0, d);
    buttons = 2'b10;
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++; if (input_data !== 16'h0000) begin n_bad++; $display("FAIL midrst_data got=%h exp=0000", input_data); end
    n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL midrst_pending got=%b exp=0", btn_pending); end
    for (int i = 0; i < DEB + 1; i++) begin
      tick();
      n_cmp++; if (btn_pending !== 1'b0) begin n_bad++; $display("FAIL midrst_early edge=%0d got=%b exp=0", i + 1, btn_pending); end
    end
    tick();
    n_cmp++; if (btn_pending !== 1'b1) begin n_bad++; $display("FAIL midrst_set got=%b exp=1", btn_pending); end
    do_read(A_LEVEL, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL midrst_level got=%h exp=0002", d); end
    do_read(A_FLAGS, d);
    n_cmp++; if (d !== 16'h0002) begin n_bad++; $display("FAIL midrst_flags got=%h exp=0002", d); end
  endtask

  initial begin
    test_reset();
    test_sync_latency();
    test_debounce_glitch();
    test_debounce_hold();
    test_read_to_clear();
    test_set_wins();
    test_back_to_back();
    test_reset_mid_debounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_input_ctrl.md
# switch_input_ctrl

Parametrised memory-mapped input controller for the CPU's I/O space, serving the on-board switches and push-buttons. It synchronises all external inputs, debounces the buttons, captures button rising edges in sticky read-to-clear flags, and returns a selected switch byte or button word on a registered 16-bit read bus. It sits behind the I/O address decoder, which asserts `switchCtrl` for the switch/button address window.

## Interface

Parameters:
- `NUM_BYTES`, 3: number of 8-bit switch groups; legal range 1..8.
- `NUM_BTNS`, 2: number of push-buttons; legal range 1..16.
- `DEBOUNCE_CYCLES`, 20000: consecutive stable cycles required before a button level is accepted; minimum 1.
- `ADDR_W`, 4: width of `switchAddr`; requires 2^ADDR_W >= NUM_BYTES+2.

Ports:
- `clock`  in  1  system clock; all logic updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `switchCtrl`  in  1  address decoder selects this block.
- `ioRead`  in  1  CPU I/O read strobe.
- `switchAddr`  in  ADDR_W  register select within the window.
- `switches`  in  8*NUM_BYTES  raw asynchronous switch inputs.
- `buttons`  in  NUM_BTNS  raw asynchronous button inputs, active-high.
- `input_data`  out  16  registered read data.
- `btn_pending`  out  1  OR of all sticky edge flags.

## Operation

- Read strobe: `rd = switchCtrl & ioRead`.
- Synchroniser: every `switches` and `buttons` bit passes through a 2-flop chain (s1 -> s2).
- Switches are not debounced. The s2 value is the switch value.
- Debounce, per button: hold a `stable` bit and a counter of width clog2(DEBOUNCE_CYCLES+1).
  - If s2 == stable, the counter clears.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1, `stable` <= s2 and the counter clears.
  - Otherwise the counter increments.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes `stable`.
- Edge flags, one sticky bit per button:
  - Set on the clock edge where `stable` goes 0 -> 1.
  - Falling transitions do nothing.
- Register map, selected by `switchAddr`:
  - 0..NUM_BYTES-1: {8'h00, switch byte k}, where byte k = bits [8k+7:8k].
  - NUM_BYTES (FLAGS): sticky flags, zero-extended to 16 bits.
  - NUM_BYTES+1 (LEVEL): debounced `stable` bits, zero-extended.
  - Any other address: 16'h0000.
- Read-to-clear:
  - A read of FLAGS returns the pre-clear flag values.
  - The same read clears all flags on that edge.
  - If a rising edge and the FLAGS read happen on the same edge, that button's flag ends set (set wins); the returned value shows its old state.
  - Reads of any other address leave the flags unchanged.
- `input_data` updates only on edges where `rd` = 1. Otherwise it holds its last value.
- `btn_pending` is combinational from the flag registers.

## Timing

- Reset values (edge with `reset` = 1):
  - `input_data` = 0, flags = 0, `stable` = 0, counters = 0, synchroniser flops = 0.
  - Hence `btn_pending` = 0.
- Reset wins over `rd` and over edge detection in the same cycle.
- Reset asserted during a debounce count discards the count.
- Read latency: `rd` sampled at edge N; `input_data` is valid after edge N, one cycle. Data reflects register contents before edge N.
- Switch latency: a raw change stable before edge N is visible to a read at edge N+2 or later.
- Button latency: a raw button held high from before edge N behaves as follows.
  - s2 = 1 after edge N+1.
  - `stable` and the flag set at edge N+1+DEBOUNCE_CYCLES.
  - `btn_pending` goes high after that edge.
- Back-to-back reads on consecutive cycles are supported. Each read is independent.
- Holding `rd` with FLAGS selected for several cycles: the first read returns the flags; later reads return 0 unless a new edge occurred.

## Test plan

- Reset and defaults: apply reset with `switches`=24'hA5C3F0 and `rd`=1. Then read addresses 0, 1, 2 → outputs 0 during reset, then 16'h00F0, 16'h00C3, 16'h00A5. Read address 7 → 16'h0000.
- Synchroniser latency: change `switches[7:0]` from 8'h00 to 8'h3C just before edge N.
  - Read addr 0 at edge N+1 → 16'h0000.
  - Read addr 0 at edge N+2 → 16'h003C.
- Debounce (DEBOUNCE_CYCLES=4):
  - Pulse `buttons[0]` high for 3 cycles → LEVEL reads 0 and `btn_pending` = 0.
  - Hold it high for 10 cycles → LEVEL = 16'h0001 and `btn_pending` = 1 exactly after edge N+5.
- Read-to-clear: with flag 1 set, read FLAGS → 16'h0002 and `btn_pending` = 0 next cycle. A second FLAGS read → 16'h0000.
- Set-wins collision: arrange `buttons[0]` to complete debounce on the same edge as a FLAGS read while flag 0 is clear. The read returns 16'h0000; the flag is 1 afterwards, and the next FLAGS read returns 16'h0001.
- Reset mid-debounce: hold `buttons[1]` high for 2 cycles of its count, pulse `reset` for 1 cycle while the button stays high. `stable` rises only DEBOUNCE_CYCLES+2 cycles after reset deasserts; no early flag is set.
